alu_control_seq: RTL and testbench
==================================

// Module: alu_control_seq
// PURPOSE
//   Next-generation EX-stage ALU control. Decodes alu_op/function_field into an ALU action code,
//   extending the base set with XOR, shifts, MULT and DIV. MULT/DIV run on a multi-cycle unit.
//   A small FSM starts that unit, counts its latency and stalls the pipeline until the result is ready.
//   Sits between ID/EX pipeline register outputs and the ALU / mul-div unit.
// PARAMETERS
//   FUNCT_W     6   width of function_field
//   ACTION_W    4   width of alu_action_out (>=4)
//   MUL_CYCLES  4   mul-div unit latency for MULT, in cycles (>=1)
//   DIV_CYCLES  16  mul-div unit latency for DIV, in cycles (>=1)
//   CNT_W       5   counter width; must hold max(MUL_CYCLES,DIV_CYCLES)-1
// PORTS
//   clk             in   1         clock, all state on rising edge
//   reset           in   1         synchronous, active-high reset
//   ex_valid        in   1         valid instruction present in EX
//   ex_flush        in   1         kill instruction in EX (branch/exception)
//   alu_op          in   2         00 add (LW/SW), 01 sub (BEQ), 10 R-type, 11 reserved
//   function_field  in   FUNCT_W   R-type function code
//   alu_action_out  out  ACTION_W  ALU action code
//   md_start        out  1         1-cycle start pulse to mul-div unit
//   md_is_div       out  1         with md_start: 1 = DIV, 0 = MULT
//   md_done         out  1         1-cycle pulse; mul-div result valid this cycle
//   ex_stall        out  1         hold IF/ID/EX; insert bubble into MEM
//   illegal_funct   out  1         R-type with undefined function code
// BEHAVIOUR
//   Decode (combinational; ACTION_W zero-extends the codes):
//   - alu_op=00 -> 0010; alu_op=01 -> 0110; alu_op=11 -> 0000.
//   - alu_op=10, by function_field:
//     - 100000 -> 0010 ADD; 100010 -> 0110 SUB; 100100 -> 0000 AND
//     - 100101 -> 0001 OR; 100110 -> 0011 XOR; 101010 -> 0111 SLT
//     - 000000 -> 1000 SLL; 000010 -> 1001 SRL; 000011 -> 1010 SRA
//     - 011000 -> 1100 MULT; 011010 -> 1101 DIV
//     - other -> 0000, with illegal_funct = ex_valid.
//   - is_md = ex_valid & alu_op=10 & (MULT|DIV).
//   FSM states IDLE, BUSY, DONE. cnt is CNT_W bits.
//   - IDLE: if is_md & !ex_flush -> md_start=1, md_is_div=DIV, ex_stall=1;
//     load cnt=LAT-1 (LAT = MUL_CYCLES or DIV_CYCLES); latch op code; go to BUSY.
//   - BUSY: ex_stall=1; alu_action_out = latched code; if cnt==0 go to DONE, else cnt-=1.
//   - DONE: md_done=1, ex_stall=0, alu_action_out = latched code; always go to IDLE.
//     No restart in DONE, even though the same instruction is still ex_valid.
//   - Timing: an op with latency LAT stalls LAT+1 cycles (start cycle + LAT BUSY cycles);
//     md_done is asserted LAT+1 cycles after md_start.
//   - ex_flush in BUSY or DONE -> IDLE next cycle, md_done not asserted, ex_stall=0 in the flush
//     cycle. The mul-div result is discarded by the unit owner.
//   - ex_flush in IDLE suppresses md_start.
//   - md_start and md_done are never asserted in the same cycle.
//   - Back-to-back MULT/DIV: the second one starts in the IDLE cycle after DONE.
//   - Reset: state=IDLE, cnt=0, latched code=0. While reset=1 all outputs are 0, including
//     alu_action_out. Reset mid-BUSY aborts with no md_done.
//   - Non-md instructions in IDLE: pure combinational decode, no stall, zero added latency.
// TESTING
//   1. Sweep all alu_op and defined funct codes with ex_valid=1 -> table codes; ex_stall=0.
//      alu_op=10, funct=111111 -> action 0000, illegal_funct=1.
//   2. MULT (011000), MUL_CYCLES=4 -> md_start at T0 with md_is_div=0; ex_stall high T0..T4;
//      md_done at T5, action 1100 T0..T5.
//   3. DIV, DIV_CYCLES=16 -> ex_stall high 17 cycles; md_done at T17; md_is_div=1 at T0.
//   4. MULT then DIV back-to-back -> second md_start at T6 only; exactly one md_start per instruction.
//   5. ex_flush at T2 of a MULT -> IDLE at T3, no md_done, ex_stall=0 at T2.
//      Repeat with reset=1 at T2 -> same, all outputs 0.
//   6. MULT with ex_flush=1 in the start cycle -> md_start=0, state stays IDLE.

Source files
------------

// File: rtl/alu_control_seq.sv
// EX-stage ALU control: decodes alu_op/function_field into an action code and sequences
// the multi-cycle mul-div unit, stalling the pipeline until its result is ready.
module alu_control_seq #(
    parameter int FUNCT_W    = 6,
    parameter int ACTION_W   = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 16,
    parameter int CNT_W      = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ex_valid,
    input  logic                ex_flush,
    input  logic [1:0]          alu_op,
    input  logic [FUNCT_W-1:0]  function_field,
    output logic [ACTION_W-1:0] alu_action_out,
    output logic                md_start,
    output logic                md_is_div,
    output logic                md_done,
    output logic                ex_stall,
    output logic                illegal_funct
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [FUNCT_W-1:0] F_ADD  = FUNCT_W'(6'b100000);
    localparam logic [FUNCT_W-1:0] F_SUB  = FUNCT_W'(6'b100010);
    localparam logic [FUNCT_W-1:0] F_AND  = FUNCT_W'(6'b100100);
    localparam logic [FUNCT_W-1:0] F_OR   = FUNCT_W'(6'b100101);
    localparam logic [FUNCT_W-1:0] F_XOR  = FUNCT_W'(6'b100110);
    localparam logic [FUNCT_W-1:0] F_SLT  = FUNCT_W'(6'b101010);
    localparam logic [FUNCT_W-1:0] F_SLL  = FUNCT_W'(6'b000000);
    localparam logic [FUNCT_W-1:0] F_SRL  = FUNCT_W'(6'b000010);
    localparam logic [FUNCT_W-1:0] F_SRA  = FUNCT_W'(6'b000011);
    localparam logic [FUNCT_W-1:0] F_MULT = FUNCT_W'(6'b011000);
    localparam logic [FUNCT_W-1:0] F_DIV  = FUNCT_W'(6'b011010);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ACTION_W-1:0]   code_q, code_d;

    logic [3:0]            dec_code;
    logic                  dec_undef;
    logic                  dec_mult;
    logic                  dec_div;
    logic                  is_md;

    logic [ACTION_W-1:0]   action;
    logic                  start;
    logic                  is_div;
    logic                  done;
    logic                  stall;

    always_comb begin
        dec_code  = 4'b0000;
        dec_undef = 1'b0;
        dec_mult  = 1'b0;
        dec_div   = 1'b0;
        unique case (alu_op)
            2'b00: dec_code = 4'b0010;
            2'b01: dec_code = 4'b0110;
            2'b11: dec_code = 4'b0000;
            default: begin
                case (function_field)
                    F_ADD:  dec_code = 4'b0010;
                    F_SUB:  dec_code = 4'b0110;
                    F_AND:  dec_code = 4'b0000;
                    F_OR:   dec_code = 4'b0001;
                    F_XOR:  dec_code = 4'b0011;
                    F_SLT:  dec_code = 4'b0111;
                    F_SLL:  dec_code = 4'b1000;
                    F_SRL:  dec_code = 4'b1001;
                    F_SRA:  dec_code = 4'b1010;
                    F_MULT: begin
                        dec_code = 4'b1100;
                        dec_mult = 1'b1;
                    end
                    F_DIV: begin
                        dec_code = 4'b1101;
                        dec_div  = 1'b1;
                    end
                    default: dec_undef = 1'b1;
                endcase
            end
        endcase
    end

    assign is_md = ex_valid & (dec_mult | dec_div);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        action  = ACTION_W'(dec_code);
        start   = 1'b0;
        is_div  = 1'b0;
        done    = 1'b0;
        stall   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (is_md && !ex_flush) begin
                    start   = 1'b1;
                    is_div  = dec_div;
                    stall   = 1'b1;
                    cnt_d   = dec_div ? DIV_LOAD : MUL_LOAD;
                    code_d  = ACTION_W'(dec_code);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                action = code_q;
                if (ex_flush) begin
                    state_d = S_IDLE;
                end else begin
                    stall = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_DONE: begin
                // The instruction is still in EX this cycle; returning to IDLE without
                // restarting lets the pipeline advance it before another op can start.
                action  = code_q;
                done    = !ex_flush;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    // Every output is forced low while reset is held, including the combinational decode.
    assign alu_action_out = reset ? '0 : action;
    assign md_start       = !reset & start;
    assign md_is_div      = !reset & is_div;
    assign md_done        = !reset & done;
    assign ex_stall       = !reset & stall;
    assign illegal_funct  = !reset & ex_valid & dec_undef;

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq: decode vector table plus multi-cycle mul-div sequences.
module tb_alu_control_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       ex_valid;
    logic       ex_flush;
    logic [1:0] alu_op;
    logic [5:0] function_field;
    logic [3:0] alu_action_out;
    logic       md_start;
    logic       md_is_div;
    logic       md_done;
    logic       ex_stall;
    logic       illegal_funct;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;

    typedef struct {
        logic       v;
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] act;
        logic       ill;
    } vec_t;

    vec_t vecs[$];

    alu_control_seq dut (
        .clk            (clk),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_flush       (ex_flush),
        .alu_op         (alu_op),
        .function_field (function_field),
        .alu_action_out (alu_action_out),
        .md_start       (md_start),
        .md_is_div      (md_is_div),
        .md_done        (md_done),
        .ex_stall       (ex_stall),
        .illegal_funct  (illegal_funct)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f, input logic fl);
        ex_valid       = v;
        alu_op         = op;
        function_field = f;
        ex_flush       = fl;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " action"}, 32'(alu_action_out), 32'h0);
        check({tag, " start"}, 32'(md_start), 32'h0);
        check({tag, " is_div"}, 32'(md_is_div), 32'h0);
        check({tag, " done"}, 32'(md_done), 32'h0);
        check({tag, " stall"}, 32'(ex_stall), 32'h0);
        check({tag, " illegal"}, 32'(illegal_funct), 32'h0);
    endtask

    // Presents one MULT/DIV from T0 and checks every cycle through its md_done at T(lat+1).
    // Returns positioned at the start of cycle T(lat+2).
    task automatic run_md(input logic div, input int lat, input string tag);
        drive(1'b1, 2'b10, div ? F_DIV : F_MULT, 1'b0);
        for (int t = 0; t <= lat + 1; t++) begin
            @(negedge clk);
            check($sformatf("%s T%0d start", tag, t), 32'(md_start), 32'(t == 0));
            if (t == 0) check($sformatf("%s T0 is_div", tag), 32'(md_is_div), 32'(div));
            check($sformatf("%s T%0d stall", tag, t), 32'(ex_stall), 32'(t <= lat));
            check($sformatf("%s T%0d done", tag, t), 32'(md_done), 32'(t == lat + 1));
            check($sformatf("%s T%0d action", tag, t), 32'(alu_action_out),
                  div ? 32'hd : 32'hc);
            tick();
        end
    endtask

    initial begin
        vecs.push_back('{1'b1, 2'b00, 6'b100010, 4'b0010, 1'b0});
        vecs.push_back('{1'b1, 2'b01, 6'b100000, 4'b0110, 1'b0});
        vecs.push_back('{1'b1, 2'b11, 6'b100000, 4'b0000, 1'b0});
        vecs.push_back('{1'b1, 2'b10, 6'b100000, 4'b0010, 1'b0});
        vecs.push_back('{1'b1, 2'b10, 6'b100010, 4'b0110, 1'b0});
        vecs.push_back('{1'b1, 2'b10, 6'b100100, 4'b0000, 1'b0});
        vecs.push_back('{1'b1, 2'b10, 6'b100101, 4'b0001, 1'b0});
        vecs.push_back('{1'b1, 2'b10, 6'b100110, 4'b0011, 1'b0});
        vecs.push_back('{1'b1, 2'b10, 6'b101010, 4'b0111, 1'b0});
        vecs.push_back('{1'b1, 2'b10, 6'b000000, 4'b1000, 1'b0});
        vecs.push_back('{1'b1, 2'b10, 6'b000010, 4'b1001, 1'b0});
        vecs.push_back('{1'b1, 2'b10, 6'b000011, 4'b1010, 1'b0});
        vecs.push_back('{1'b1, 2'b10, 6'b111111, 4'b0000, 1'b1});
        vecs.push_back('{1'b1, 2'b10, 6'b000001, 4'b0000, 1'b1});
        vecs.push_back('{1'b0, 2'b10, 6'b111111, 4'b0000, 1'b0});
        vecs.push_back('{1'b0, 2'b10, F_MULT,    4'b1100, 1'b0});
        vecs.push_back('{1'b0, 2'b10, F_DIV,     4'b1101, 1'b0});

        // Reset held with a live instruction: every output must stay low.
        reset = 1'b1;
        drive(1'b1, 2'b10, F_MULT, 1'b0);
        tick();
        tick();
        @(negedge clk);
        check_all_zero("reset held");
        tick();
        reset = 1'b0;
        drive(1'b0, 2'b00, 6'b0, 1'b0);
        tick();

        // Combinational decode sweep; none of these may start the mul-div unit.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].op, vecs[i].f, 1'b0);
            @(negedge clk);
            check($sformatf("vec%0d action", i), 32'(alu_action_out), 32'(vecs[i].act));
            check($sformatf("vec%0d illegal", i), 32'(illegal_funct), 32'(vecs[i].ill));
            check($sformatf("vec%0d stall", i), 32'(ex_stall), 32'h0);
            check($sformatf("vec%0d start", i), 32'(md_start), 32'h0);
            tick();
        end

        // Single MULT, single DIV, then MULT immediately followed by DIV.
        run_md(1'b0, 4, "mult");
        drive(1'b0, 2'b00, 6'b0, 1'b0);
        tick();
        run_md(1'b1, 16, "div");
        drive(1'b0, 2'b00, 6'b0, 1'b0);
        tick();
        run_md(1'b0, 4, "b2b mult");
        run_md(1'b1, 16, "b2b div");
        drive(1'b0, 2'b00, 6'b0, 1'b0);
        tick();

        // Flush at T2 of a MULT; a fresh MULT at T3 must start at once (FSM back in IDLE),
        // and the aborted op's md_done slot at T5 must stay quiet.
        drive(1'b1, 2'b10, F_MULT, 1'b0);
        @(negedge clk);
        check("flush T0 start", 32'(md_start), 32'h1);
        tick();
        @(negedge clk);
        check("flush T1 stall", 32'(ex_stall), 32'h1);
        tick();
        ex_flush = 1'b1;
        @(negedge clk);
        check("flush T2 stall", 32'(ex_stall), 32'h0);
        check("flush T2 done", 32'(md_done), 32'h0);
        check("flush T2 start", 32'(md_start), 32'h0);
        tick();
        run_md(1'b0, 4, "after flush");
        drive(1'b0, 2'b00, 6'b0, 1'b0);
        tick();

        // Same scenario with reset asserted at T2.
        drive(1'b1, 2'b10, F_MULT, 1'b0);
        @(negedge clk);
        check("rst T0 start", 32'(md_start), 32'h1);
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("rst T2");
        tick();
        reset = 1'b0;
        run_md(1'b0, 4, "after reset");
        drive(1'b0, 2'b00, 6'b0, 1'b0);
        tick();

        // Flush in the start cycle suppresses md_start; the op starts once flush drops.
        drive(1'b1, 2'b10, F_MULT, 1'b1);
        @(negedge clk);
        check("start flush start", 32'(md_start), 32'h0);
        check("start flush stall", 32'(ex_stall), 32'h0);
        tick();
        run_md(1'b0, 4, "post start flush");
        drive(1'b0, 2'b00, 6'b0, 1'b0);
        tick();

        // Flush in DONE: no md_done, no stall, and IDLE afterwards.
        drive(1'b1, 2'b10, F_DIV, 1'b0);
        for (int t = 0; t < 17; t++) tick();
        ex_flush = 1'b1;
        @(negedge clk);
        check("done flush done", 32'(md_done), 32'h0);
        check("done flush stall", 32'(ex_stall), 32'h0);
        tick();
        run_md(1'b0, 4, "after done flush");
        drive(1'b0, 2'b00, 6'b0, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
